ifu: RTL and testbench
======================

IFU -- requirements
Module: ifu

Interface
REQ-001 Parameter RESET_PC, default 64'h8000_0000, is the first fetch address after reset.
REQ-002 clock  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 redirect_valid_i  input  1  flush request from E (branch/jump/trap).
REQ-005 redirect_pc_i  input  64  next fetch address when redirect_valid_i=1.
REQ-006 imem_req_valid_o  output  1  fetch request valid.
REQ-007 imem_req_ready_i  input  1  memory accepts request.
REQ-008 imem_req_addr_o  output  64  fetch address.
REQ-009 imem_rsp_valid_i  input  1  response valid; memory SHALL never stall a response.
REQ-010 imem_rsp_data_i  input  32  fetched instruction.
REQ-011 imem_rsp_err_i  input  1  access fault for this response.
REQ-012 f_valid_o  output  1  instruction valid to D-pipe.
REQ-013 D_ready_i  input  1  D-pipe accepts instruction.
REQ-014 inst_o  output  32  instruction to D-pipe.
REQ-015 pc_o  output  64  PC of inst_o.
REQ-016 fetch_err_o  output  1  inst_o carries an instruction-fetch fault.

Function
REQ-017 FSM states BOOT, REQ, WAIT, HOLD; exactly one request outstanding at any time.
REQ-018 BOOT: all valids 0; next state REQ unconditionally.
REQ-019 REQ: imem_req_valid_o=1, imem_req_addr_o=pc; on imem_req_ready_i go WAIT, else stay.
REQ-020 WAIT: on imem_rsp_valid_i with kill=0, latch data/err into inst/err registers and go HOLD; with kill=1, discard, clear kill, go REQ.
REQ-021 HOLD: f_valid_o=(state==HOLD)&~redirect_valid_i; on f_valid_o&D_ready_i, pc<=pc+4 (64-bit wrap), go REQ.
REQ-022 Redirect in REQ without handshake: pc<=redirect_pc_i, stay REQ; the address changes the next cycle.
REQ-023 Redirect in REQ with handshake in the same cycle: pc<=redirect_pc_i, kill<=1, go WAIT.
REQ-024 Redirect in WAIT without response: pc<=redirect_pc_i, kill<=1; redirect together with response: discard response, pc<=redirect_pc_i, go REQ.
REQ-025 Redirect in HOLD: pc<=redirect_pc_i, go REQ; redirect has priority over D_ready_i, and the held instruction is never accepted.
REQ-026 Response with imem_rsp_err_i=1: inst_o=32'h0000_0013 (NOP), fetch_err_o=1, pc_o=faulting PC; handshake otherwise normal.
REQ-027 inst_o, pc_o and fetch_err_o SHALL be stable while f_valid_o=1 and D_ready_i=0.
REQ-028 Throughput with a one-cycle memory and D_ready_i=1 is one instruction per 3 cycles (REQ->WAIT->HOLD).

Reset
REQ-029 Reset values: state=BOOT, pc=RESET_PC, kill=0, inst=0, err=0; all outputs 0 except pc_o=RESET_PC.
REQ-030 Reset asserted mid-transaction aborts it; a later stale response while in BOOT or REQ SHALL be ignored.

Configuration
REQ-031 Macro YSYX_23060251_IFU_ALIGN_CHK_EN defined: a redirect with redirect_pc_i[1:0]!=0 issues no memory request; the IFU enters HOLD with fetch_err_o=1, inst_o=NOP, pc_o=target.
REQ-032 Macro undefined: the check is absent and the address is fetched as given.

Structure
REQ-033 The shared defines header SHALL hold the FSM state encoding, the RESET_PC default and the NOP constant.
REQ-034 No sub-module: the block is a single module with PC, kill flag, and instruction/error holding registers.

Verification
REQ-035 Reset, then ready=1 and one-cycle response 32'h00100093 -> request addr 8000_0000 on cycle 1; f_valid_o on cycle 3 with pc_o 8000_0000.
REQ-036 HOLD with D_ready_i=0 for 5 cycles -> outputs stable; then ready=1 -> next request addr 8000_0004.
REQ-037 Redirect to 8000_0100 while in WAIT -> late response dropped, f_valid_o stays 0, next request addr 8000_0100.
REQ-038 Redirect in HOLD together with D_ready_i=1 -> f_valid_o=0 that cycle, next request addr equals the target.
REQ-039 imem_rsp_err_i=1 -> inst_o 0000_0013, fetch_err_o=1; with the macro on, redirect to 8000_0102 -> error with no request issued.
REQ-040 pc=FFFF_FFFF_FFFF_FFFC accepted -> next request addr 0.

Source files
------------

// File: rtl/ifu_pkg.sv
// ifu_pkg: shared IFU definitions -- FSM state encoding, default reset PC and the NOP used for faulted fetches.
package ifu_pkg;
    typedef enum logic [1:0] {BOOT, REQ, WAIT, HOLD} state_t;
    localparam logic [63:0] RESET_PC_DEF = 64'h8000_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;
endpackage

// File: rtl/ifu.sv
// ifu: single-outstanding instruction fetch unit with redirect/kill handling.
// Optional YSYX_23060251_IFU_ALIGN_CHK_EN turns misaligned redirect targets into fetch faults without a memory request.
module ifu
    import ifu_pkg::*;
#(
    parameter logic [63:0] RESET_PC = RESET_PC_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        redirect_valid_i,
    input  logic [63:0] redirect_pc_i,
    output logic        imem_req_valid_o,
    input  logic        imem_req_ready_i,
    output logic [63:0] imem_req_addr_o,
    input  logic        imem_rsp_valid_i,
    input  logic [31:0] imem_rsp_data_i,
    input  logic        imem_rsp_err_i,
    output logic        f_valid_o,
    input  logic        D_ready_i,
    output logic [31:0] inst_o,
    output logic [63:0] pc_o,
    output logic        fetch_err_o
);
    state_t      state;
    logic [63:0] pc;
    logic        kill;
    logic [31:0] inst;
    logic        err;
    logic        hs;
    logic        bad_tgt;
    logic        bad_pc;

    assign hs = (state == REQ) & imem_req_ready_i;
`ifdef YSYX_23060251_IFU_ALIGN_CHK_EN
    assign bad_tgt = |redirect_pc_i[1:0];
    assign bad_pc  = |pc[1:0];
`else
    assign bad_tgt = 1'b0;
    assign bad_pc  = 1'b0;
`endif

    assign imem_req_valid_o = state == REQ;
    assign imem_req_addr_o  = (state == REQ) ? pc : '0;
    assign f_valid_o        = (state == HOLD) & ~redirect_valid_i;
    assign inst_o           = inst;
    assign pc_o             = pc;
    assign fetch_err_o      = err;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= BOOT;
            pc    <= RESET_PC;
            kill  <= 1'b0;
            inst  <= '0;
            err   <= 1'b0;
        end else begin
            case (state)
                BOOT: state <= REQ;
                REQ: begin
                    if (redirect_valid_i) begin
                        pc <= redirect_pc_i;
                        // an accepted request must still be drained before a faulting target can be held
                        if (hs) begin
                            kill  <= 1'b1;
                            state <= WAIT;
                        end else if (bad_tgt) begin
                            inst  <= NOP;
                            err   <= 1'b1;
                            state <= HOLD;
                        end
                    end else if (hs) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid_i) begin
                        kill <= 1'b0;
                        if (redirect_valid_i) begin
                            pc    <= redirect_pc_i;
                            inst  <= bad_tgt ? NOP : inst;
                            err   <= bad_tgt | err;
                            state <= bad_tgt ? HOLD : REQ;
                        end else if (kill) begin
                            inst  <= bad_pc ? NOP : inst;
                            err   <= bad_pc | err;
                            state <= bad_pc ? HOLD : REQ;
                        end else begin
                            inst  <= imem_rsp_err_i ? NOP : imem_rsp_data_i;
                            err   <= imem_rsp_err_i;
                            state <= HOLD;
                        end
                    end else if (redirect_valid_i) begin
                        pc   <= redirect_pc_i;
                        kill <= 1'b1;
                    end
                end
                HOLD: begin
                    if (redirect_valid_i) begin
                        pc    <= redirect_pc_i;
                        inst  <= bad_tgt ? NOP : inst;
                        err   <= bad_tgt | err;
                        state <= bad_tgt ? HOLD : REQ;
                    end else if (D_ready_i) begin
                        pc    <= pc + 64'd4;
                        state <= REQ;
                    end
                end
                default: state <= BOOT;
            endcase
        end
    end
endmodule

// File: tb/tb_ifu.sv
// tb_ifu: program-order reference model plus bench-side memory, directed scenarios then randomized traffic.
module tb_ifu;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        redirect_valid_i = 1'b0;
    logic [63:0] redirect_pc_i = '0;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i = 1'b0;
    logic [63:0] imem_req_addr_o;
    logic        imem_rsp_valid_i = 1'b0;
    logic [31:0] imem_rsp_data_i = '0;
    logic        imem_rsp_err_i = 1'b0;
    logic        f_valid_o;
    logic        D_ready_i = 1'b0;
    logic [31:0] inst_o;
    logic [63:0] pc_o;
    logic        fetch_err_o;

    localparam logic [63:0] RST = 64'h8000_0000;
    localparam logic [31:0] NOPI = 32'h0000_0013;

    ifu dut (
        .clock(clock), .reset(reset),
        .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i),
        .imem_req_valid_o(imem_req_valid_o), .imem_req_ready_i(imem_req_ready_i),
        .imem_req_addr_o(imem_req_addr_o), .imem_rsp_valid_i(imem_rsp_valid_i),
        .imem_rsp_data_i(imem_rsp_data_i), .imem_rsp_err_i(imem_rsp_err_i),
        .f_valid_o(f_valid_o), .D_ready_i(D_ready_i), .inst_o(inst_o),
        .pc_o(pc_o), .fetch_err_o(fetch_err_o)
    );

    always #5 clock = ~clock;

    int checks = 0, errors = 0;
    logic [63:0] arch_pc = RST;
    bit mis, busy, after_rst, prev_stall, pend, rnd;
    logic [31:0] p_inst;
    logic [63:0] p_pc, m_addr;
    logic p_err;
    int acc = 0, cnt = 0, lat = 1;

    function automatic logic [31:0] mem_data(logic [63:0] a);
        return (a == RST) ? 32'h0010_0093 : a[31:0] ^ a[63:32] ^ 32'h1357_9BDF;
    endfunction

    function automatic logic mem_err(logic [63:0] a);
        return a[11:2] == 10'h080;
    endfunction

    task automatic chk(string n, logic [63:0] a, logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    // Model: arch_pc is the next instruction the D-pipe must see in program order.
    task automatic check();
        bit hs, e_err;
        hs = imem_req_valid_o & imem_req_ready_i;
        if (hs) begin
            pend   = 1;
            cnt    = rnd ? $urandom_range(0, 2) : lat - 1;
            m_addr = imem_req_addr_o;
        end
        if (reset) begin
            arch_pc = RST; mis = 0; busy = 0; prev_stall = 0; after_rst = 1;
            return;
        end
        if (after_rst) begin
            chk("rst_req_valid", 64'(imem_req_valid_o), 0);
            chk("rst_req_addr", imem_req_addr_o, 0);
            chk("rst_f_valid", 64'(f_valid_o), 0);
            chk("rst_pc", pc_o, RST);
            chk("rst_inst", 64'(inst_o), 0);
            chk("rst_err", 64'(fetch_err_o), 0);
            after_rst = 0;
        end
        if (redirect_valid_i) chk("fvalid_under_redirect", 64'(f_valid_o), 0);
        if (prev_stall && !redirect_valid_i) begin
            chk("stall_fvalid", 64'(f_valid_o), 1);
            chk("stall_inst", 64'(inst_o), 64'(p_inst));
            chk("stall_pc", pc_o, p_pc);
            chk("stall_err", 64'(fetch_err_o), 64'(p_err));
        end
        if (imem_rsp_valid_i) busy = 0;
        if (hs) begin
            chk("one_outstanding", 64'(busy), 0);
            chk("req_addr", imem_req_addr_o, arch_pc);
            if (mis) chk("req_while_misaligned", 64'(imem_req_valid_o), 0);
            busy = 1;
        end
        if (f_valid_o && D_ready_i) begin
            e_err = mis | mem_err(arch_pc);
            chk("acc_pc", pc_o, arch_pc);
            chk("acc_inst", 64'(inst_o), 64'(e_err ? NOPI : mem_data(arch_pc)));
            chk("acc_err", 64'(fetch_err_o), 64'(e_err));
            arch_pc = arch_pc + 64'd4;
            mis = 0;
            acc++;
        end
        prev_stall = f_valid_o & ~D_ready_i;
        p_inst = inst_o; p_pc = pc_o; p_err = fetch_err_o;
        if (redirect_valid_i) begin
            arch_pc = redirect_pc_i;
            mis = 0;
`ifdef YSYX_23060251_IFU_ALIGN_CHK_EN
            mis = |redirect_pc_i[1:0];
`endif
        end
    endtask

    task automatic drive();
        logic [63:0] t;
        imem_rsp_valid_i = 0;
        imem_rsp_data_i  = $urandom;
        imem_rsp_err_i   = 1'($urandom);
        if (pend) begin
            if (cnt == 0) begin
                imem_rsp_valid_i = 1;
                imem_rsp_data_i  = mem_data(m_addr);
                imem_rsp_err_i   = mem_err(m_addr);
                pend = 0;
            end else cnt--;
        end
        if (rnd) begin
            imem_req_ready_i = $urandom_range(0, 9) < 7;
            D_ready_i        = $urandom_range(0, 9) < 6;
            redirect_valid_i = $urandom_range(0, 9) == 0;
            t = RST + {50'd0, 12'($urandom), 2'b00};
            if ($urandom_range(0, 7) == 0) t[1:0] = 2'($urandom);
            if ($urandom_range(0, 15) == 0) t = 64'hFFFF_FFFF_FFFF_FFF0 | {60'd0, 4'($urandom)};
            redirect_pc_i = t;
        end
    endtask

    task automatic tick();
        @(negedge clock);
        check();
        @(posedge clock);
        #1;
        drive();
    endtask

    initial begin
        int a0;
        tick();
        chk("boot_pc", pc_o, RST);
        chk("boot_req_valid", 64'(imem_req_valid_o), 0);
        chk("boot_f_valid", 64'(f_valid_o), 0);
        reset = 0;
        imem_req_ready_i = 1;
        tick();
        chk("c1_req_valid", 64'(imem_req_valid_o), 1);
        chk("c1_req_addr", imem_req_addr_o, 64'h8000_0000);
        tick();
        tick();
        chk("c3_f_valid", 64'(f_valid_o), 1);
        chk("c3_pc", pc_o, 64'h8000_0000);
        chk("c3_inst", 64'(inst_o), 64'h0010_0093);
        repeat (5) begin
            tick();
            chk("hold_f_valid", 64'(f_valid_o), 1);
            chk("hold_inst", 64'(inst_o), 64'h0010_0093);
        end
        D_ready_i = 1;
        tick();
        chk("next_req_addr", imem_req_addr_o, 64'h8000_0004);
        lat = 2;
        tick();
        redirect_valid_i = 1;
        redirect_pc_i = 64'h8000_0100;
        tick();
        redirect_valid_i = 0;
        #1 chk("killed_rsp_f_valid", 64'(f_valid_o), 0);
        lat = 1;
        tick();
        chk("redir_wait_addr", imem_req_addr_o, 64'h8000_0100);
        tick();
        tick();
        redirect_valid_i = 1;
        redirect_pc_i = 64'h8000_0200;
        #1 chk("redir_hold_f_valid", 64'(f_valid_o), 0);
        tick();
        redirect_valid_i = 0;
        chk("redir_hold_addr", imem_req_addr_o, 64'h8000_0200);
        tick();
        tick();
        chk("fault_f_valid", 64'(f_valid_o), 1);
        chk("fault_inst", 64'(inst_o), 64'h0000_0013);
        chk("fault_err", 64'(fetch_err_o), 1);
        chk("fault_pc", pc_o, 64'h8000_0200);
        tick();
        imem_req_ready_i = 0;
        redirect_valid_i = 1;
`ifdef YSYX_23060251_IFU_ALIGN_CHK_EN
        redirect_pc_i = 64'h8000_0102;
        tick();
        redirect_valid_i = 0;
        #1;
        chk("mis_no_req", 64'(imem_req_valid_o), 0);
        chk("mis_f_valid", 64'(f_valid_o), 1);
        chk("mis_err", 64'(fetch_err_o), 1);
        chk("mis_inst", 64'(inst_o), 64'h0000_0013);
        chk("mis_pc", pc_o, 64'h8000_0102);
        redirect_valid_i = 1;
        imem_req_ready_i = 1;
`endif
        redirect_pc_i = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        redirect_valid_i = 0;
        imem_req_ready_i = 1;
        #1 chk("top_req_addr", imem_req_addr_o, 64'hFFFF_FFFF_FFFF_FFFC);
        tick();
        tick();
        chk("top_pc", pc_o, 64'hFFFF_FFFF_FFFF_FFFC);
        tick();
        chk("wrap_req_addr", imem_req_addr_o, 64'h0);
        a0 = acc;
        repeat (30) tick();
        chk("throughput", 64'(acc - a0), 10);
        lat = 2;
        tick();
        reset = 1;
        tick();
        reset = 0;
        lat = 1;
        tick();
        tick();
        tick();
        chk("post_rst_f_valid", 64'(f_valid_o), 1);
        chk("post_rst_pc", pc_o, RST);
        chk("post_rst_inst", 64'(inst_o), 64'h0010_0093);
        a0 = acc;
        rnd = 1;
        repeat (4000) tick();
        rnd = 0;
        redirect_valid_i = 0;
        chk("random_progress", 64'(acc - a0 > 50), 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
